// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// OBI-side PMA tracker: queues the PMA status of each granted transfer and replays it at rvalid.
// Flags bus-visible PMA violations and OBI protocol errors (unstable request, FIFO over/underflow).

package uvmt_cv32e40x_pma_obi_tracker_pkg;

    typedef struct packed {
        logic allow;
        logic main;
        logic bufferable;
        logic cacheable;
        logic atomic;
    } pma_status_t;

endpackage

module uvmt_cv32e40x_pma_obi_tracker
    import uvmt_cv32e40x_pma_obi_tracker_pkg::*;
#(
    parameter int unsigned IS_INSTR_SIDE   = 0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        obi_req_i,
    input  logic        obi_gnt_i,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [1:0]  obi_memtype_i,
    input  logic        obi_rvalid_i,
    input  pma_status_t pma_status_i,
    output logic        resp_valid_o,
    output pma_status_t resp_status_o,
    output logic [3:0]  outstanding_o,
    output logic        err_disallowed_o,
    output logic        err_memtype_o,
    output logic        err_unstable_o,
    output logic        err_overflow_o,
    output logic        err_underflow_o,
    output logic        err_sticky_o
);

    localparam int unsigned PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // In-order status queue
    pma_status_t   fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;

    // Address-phase capture while the request is stalled
    logic          stall_q, stall_d;
    logic [31:0]   cap_addr_q, cap_addr_d;
    logic          cap_we_q, cap_we_d;
    logic [1:0]    cap_memtype_q, cap_memtype_d;

    logic          sticky_q, sticky_d;

    logic          accept;
    logic          retire;
    logic          full;
    logic          push;
    logic          pop;
    logic          exp_bufferable;
    logic [1:0]    exp_memtype;
    logic          any_err;

    assign accept = obi_req_i && obi_gnt_i;
    assign retire = obi_rvalid_i && (count_q != 4'd0);
    assign full   = (count_q == MAX_CNT);
    // A retire in the same cycle frees the head slot, so a full queue can still take a push.
    assign push   = accept && (!full || retire);
    assign pop    = retire;

    assign resp_valid_o  = retire;
    assign resp_status_o = retire ? fifo_q[rd_ptr_q] : '0;
    assign outstanding_o = count_q;

    // Non-writes never see bufferable on the bus, so the expected bit is forced low.
    assign exp_bufferable = ((IS_INSTR_SIDE != 0) || !obi_we_i) ? 1'b0 : pma_status_i.bufferable;
    assign exp_memtype    = {pma_status_i.cacheable, exp_bufferable};

    assign err_disallowed_o = accept && !pma_status_i.allow;
    assign err_memtype_o    = accept && (obi_memtype_i != exp_memtype);
    assign err_overflow_o   = accept && full && !retire;
    assign err_underflow_o  = obi_rvalid_i && (count_q == 4'd0);
    assign err_unstable_o   = stall_q && (!obi_req_i
                                          || (obi_addr_i    != cap_addr_q)
                                          || (obi_we_i      != cap_we_q)
                                          || (obi_memtype_i != cap_memtype_q));

    assign any_err = err_disallowed_o || err_memtype_o || err_unstable_o
                  || err_overflow_o || err_underflow_o;

    assign err_sticky_o = sticky_q;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stall_d       = 1'b0;
        cap_addr_d    = cap_addr_q;
        cap_we_d      = cap_we_q;
        cap_memtype_d = cap_memtype_q;
        // A violation disarms the check; the next stalled request re-arms it.
        if (!err_unstable_o && obi_req_i && !obi_gnt_i) begin
            stall_d       = 1'b1;
            cap_addr_d    = obi_addr_i;
            cap_we_d      = obi_we_i;
            cap_memtype_d = obi_memtype_i;
        end
    end

    assign sticky_d = sticky_q || any_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= pma_status_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            stall_q       <= 1'b0;
            cap_addr_q    <= '0;
            cap_we_q      <= 1'b0;
            cap_memtype_q <= '0;
            sticky_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            stall_q       <= stall_d;
            cap_addr_q    <= cap_addr_d;
            cap_we_q      <= cap_we_d;
            cap_memtype_q <= cap_memtype_d;
            sticky_q      <= sticky_d;
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
// Directed bench for the OBI PMA tracker (data side, depth 2).
module tb_uvmt_cv32e40x_pma_obi_tracker;
    import uvmt_cv32e40x_pma_obi_tracker_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        obi_req_i;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [1:0]  obi_memtype_i;
    logic        obi_rvalid_i;
    pma_status_t pma_status_i;
    logic        resp_valid_o;
    pma_status_t resp_status_o;
    logic [3:0]  outstanding_o;
    logic        err_disallowed_o;
    logic        err_memtype_o;
    logic        err_unstable_o;
    logic        err_overflow_o;
    logic        err_underflow_o;
    logic        err_sticky_o;

    int total = 0;
    int bad   = 0;

    uvmt_cv32e40x_pma_obi_tracker #(
        .IS_INSTR_SIDE  (0),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .obi_req_i       (obi_req_i),
        .obi_gnt_i       (obi_gnt_i),
        .obi_addr_i      (obi_addr_i),
        .obi_we_i        (obi_we_i),
        .obi_memtype_i   (obi_memtype_i),
        .obi_rvalid_i    (obi_rvalid_i),
        .pma_status_i    (pma_status_i),
        .resp_valid_o    (resp_valid_o),
        .resp_status_o   (resp_status_o),
        .outstanding_o   (outstanding_o),
        .err_disallowed_o(err_disallowed_o),
        .err_memtype_o   (err_memtype_o),
        .err_unstable_o  (err_unstable_o),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o),
        .err_sticky_o    (err_sticky_o)
    );

    always #5 clk = ~clk;

    function automatic pma_status_t mk(input logic allow, input logic cache, input logic buff);
        pma_status_t s;
        s.allow      = allow;
        s.main       = 1'b1;
        s.bufferable = buff;
        s.cacheable  = cache;
        s.atomic     = 1'b0;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        obi_req_i     = 1'b0;
        obi_gnt_i     = 1'b0;
        obi_addr_i    = '0;
        obi_we_i      = 1'b0;
        obi_memtype_i = 2'b00;
        obi_rvalid_i  = 1'b0;
        pma_status_i  = '0;
    endtask

    task automatic drive(input logic req, input logic gnt, input logic [31:0] addr,
                         input logic we, input logic [1:0] mt, input logic rv,
                         input pma_status_t st);
        obi_req_i     = req;
        obi_gnt_i     = gnt;
        obi_addr_i    = addr;
        obi_we_i      = we;
        obi_memtype_i = mt;
        obi_rvalid_i  = rv;
        pma_status_i  = st;
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        total++;
        if ({resp_valid_o, outstanding_o, err_disallowed_o, err_memtype_o, err_unstable_o,
             err_overflow_o, err_underflow_o, err_sticky_o} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got vld=%b out=%0d errs=%b%b%b%b%b sticky=%b want all 0",
                     resp_valid_o, outstanding_o, err_disallowed_o, err_memtype_o,
                     err_unstable_o, err_overflow_o, err_underflow_o, err_sticky_o);
        end
        total++;
        if (resp_status_o !== pma_status_t'('0)) begin
            bad++;
            $display("FAIL reset_status got %h want 0", resp_status_o);
        end
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        pma_status_t s1;
        s1 = mk(1'b1, 1'b0, 1'b0);
        apply_reset();
        drive(1'b1, 1'b1, 32'h1000, 1'b0, 2'b00, 1'b0, s1);
        total++;
        if ({err_disallowed_o, err_memtype_o, err_overflow_o, resp_valid_o} !== 4'b0000) begin
            bad++;
            $display("FAIL basic_accept_errs got %b%b%b%b want 0000",
                     err_disallowed_o, err_memtype_o, err_overflow_o, resp_valid_o);
        end
        step();
        idle();
        #1;
        total++;
        if (outstanding_o !== 4'd1) begin
            bad++;
            $display("FAIL basic_outstanding1 got %0d want 1", outstanding_o);
        end
        step();
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
        total++;
        if (resp_valid_o !== 1'b1 || resp_status_o !== s1) begin
            bad++;
            $display("FAIL basic_resp got vld=%b st=%h want vld=1 st=%h",
                     resp_valid_o, resp_status_o, s1);
        end
        step();
        idle();
        #1;
        total++;
        if (outstanding_o !== 4'd0 || err_sticky_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain got out=%0d sticky=%b want 0/0", outstanding_o, err_sticky_o);
        end
    endtask

    task automatic test_back_to_back();
        pma_status_t sa, sb, sc, sd;
        sa = mk(1'b1, 1'b0, 1'b0);
        sb = mk(1'b1, 1'b1, 1'b0);
        sc = mk(1'b1, 1'b1, 1'b1);
        sd = mk(1'b1, 1'b0, 1'b1);
        apply_reset();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 2'b00, 1'b0, sa);
        step();
        drive(1'b1, 1'b1, 32'h104, 1'b0, 2'b10, 1'b0, sb);
        step();
        total++;
        if (outstanding_o !== 4'd2) begin
            bad++;
            $display("FAIL b2b_full got %0d want 2", outstanding_o);
        end
        drive(1'b1, 1'b1, 32'h108, 1'b1, 2'b11, 1'b1, sc);
        total++;
        if (resp_valid_o !== 1'b1 || resp_status_o !== sa || err_overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_swap got vld=%b st=%h ovf=%b want 1 %h 0",
                     resp_valid_o, resp_status_o, err_overflow_o, sa);
        end
        step();
        drive(1'b1, 1'b1, 32'h10c, 1'b1, 2'b01, 1'b0, sd);
        total++;
        if (outstanding_o !== 4'd2 || err_overflow_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_overflow got out=%0d ovf=%b want 2 1", outstanding_o, err_overflow_o);
        end
        step();
        idle();
        #1;
        total++;
        if (outstanding_o !== 4'd2 || err_sticky_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_after_ovf got out=%0d sticky=%b want 2 1", outstanding_o, err_sticky_o);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
        total++;
        if (resp_status_o !== sb) begin
            bad++;
            $display("FAIL b2b_drain_b got %h want %h", resp_status_o, sb);
        end
        step();
        #1;
        total++;
        if (resp_status_o !== sc) begin
            bad++;
            $display("FAIL b2b_drain_c got %h want %h (overflowed push must be dropped)",
                     resp_status_o, sc);
        end
        step();
        idle();
        #1;
        total++;
        if (outstanding_o !== 4'd0) begin
            bad++;
            $display("FAIL b2b_empty got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
        total++;
        if (err_underflow_o !== 1'b1 || resp_valid_o !== 1'b0 || err_sticky_o !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse got unf=%b vld=%b sticky=%b want 1 0 0",
                     err_underflow_o, resp_valid_o, err_sticky_o);
        end
        step();
        idle();
        #1;
        total++;
        if (err_sticky_o !== 1'b1 || outstanding_o !== 4'd0) begin
            bad++;
            $display("FAIL underflow_sticky got sticky=%b out=%0d want 1 0", err_sticky_o, outstanding_o);
        end
    endtask

    task automatic test_unstable();
        pma_status_t s;
        s = mk(1'b1, 1'b0, 1'b0);
        apply_reset();
        drive(1'b1, 1'b0, 32'h2000, 1'b0, 2'b00, 1'b0, s);
        total++;
        if (err_unstable_o !== 1'b0) begin
            bad++;
            $display("FAIL unstable_first got %b want 0", err_unstable_o);
        end
        step();
        drive(1'b1, 1'b0, 32'h2004, 1'b0, 2'b00, 1'b0, s);
        total++;
        if (err_unstable_o !== 1'b1) begin
            bad++;
            $display("FAIL unstable_addr got %b want 1", err_unstable_o);
        end
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h3000, 1'b1, 2'b00, 1'b0, s);
        step();
        drive(1'b1, 1'b1, 32'h3000, 1'b1, 2'b00, 1'b0, s);
        total++;
        if (err_unstable_o !== 1'b0) begin
            bad++;
            $display("FAIL unstable_stable_stall got %b want 0", err_unstable_o);
        end
        step();
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
        total++;
        if (err_unstable_o !== 1'b0 || resp_status_o !== s) begin
            bad++;
            $display("FAIL unstable_cleared got unst=%b st=%h want 0 %h", err_unstable_o, resp_status_o, s);
        end
        step();
        idle();
    endtask

    task automatic test_attributes();
        pma_status_t s3, s4;
        s3 = mk(1'b1, 1'b0, 1'b1);
        s4 = mk(1'b1, 1'b1, 1'b1);
        apply_reset();
        drive(1'b1, 1'b1, 32'h4000, 1'b0, 2'b00, 1'b0, mk(1'b0, 1'b0, 1'b0));
        total++;
        if (err_disallowed_o !== 1'b1 || err_memtype_o !== 1'b0) begin
            bad++;
            $display("FAIL attr_disallowed got dis=%b mt=%b want 1 0", err_disallowed_o, err_memtype_o);
        end
        step();
        drive(1'b1, 1'b1, 32'h4004, 1'b1, 2'b00, 1'b1, mk(1'b1, 1'b0, 1'b1));
        total++;
        if (err_memtype_o !== 1'b1 || err_disallowed_o !== 1'b0) begin
            bad++;
            $display("FAIL attr_write_buf got mt=%b dis=%b want 1 0", err_memtype_o, err_disallowed_o);
        end
        step();
        drive(1'b1, 1'b1, 32'h4008, 1'b0, 2'b01, 1'b1, s3);
        total++;
        if (err_memtype_o !== 1'b1) begin
            bad++;
            $display("FAIL attr_load_buf got %b want 1", err_memtype_o);
        end
        step();
        drive(1'b1, 1'b1, 32'h400c, 1'b1, 2'b11, 1'b1, s4);
        total++;
        if (err_memtype_o !== 1'b0 || resp_status_o !== s3 || err_underflow_o !== 1'b0) begin
            bad++;
            $display("FAIL attr_write_ok got mt=%b st=%h unf=%b want 0 %h 0",
                     err_memtype_o, resp_status_o, err_underflow_o, s3);
        end
        step();
        drive(1'b1, 1'b1, 32'h4010, 1'b0, 2'b00, 1'b1, mk(1'b1, 1'b1, 1'b0));
        total++;
        if (err_memtype_o !== 1'b1 || resp_status_o !== s4) begin
            bad++;
            $display("FAIL attr_load_cache got mt=%b st=%h want 1 %h", err_memtype_o, resp_status_o, s4);
        end
        step();
        idle();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        drive(1'b1, 1'b1, 32'h5000, 1'b0, 2'b00, 1'b0, mk(1'b1, 1'b0, 1'b0));
        step();
        drive(1'b1, 1'b1, 32'h5004, 1'b0, 2'b00, 1'b0, mk(1'b1, 1'b0, 1'b0));
        step();
        idle();
        #1;
        total++;
        if (outstanding_o !== 4'd2) begin
            bad++;
            $display("FAIL midrst_before got %0d want 2", outstanding_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if (outstanding_o !== 4'd0) begin
            bad++;
            $display("FAIL midrst_async got %0d want 0", outstanding_o);
        end
        rst = 1'b0;
        step();
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
        total++;
        if (err_underflow_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL midrst_underflow got unf=%b vld=%b want 1 0", err_underflow_o, resp_valid_o);
        end
        step();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_underflow();
        test_unstable();
        test_attributes();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
